// File: rtl/avmm_pkg.sv
// Shared types and default constants for the Avalon-MM bus initiator.
// The VERIFY states exist only when AVMM_INITIATOR_VERIFY_EN is defined.
package avmm_pkg;

    localparam int AVMM_ADDR_W       = 2;
    localparam int AVMM_DATA_W       = 32;
    localparam int AVMM_READ_LATENCY = 1;
    localparam int AVMM_TIMEOUT_CYC  = 16;

    typedef enum logic [2:0] {
        ST_IDLE        = 3'd0,
        ST_ACCESS      = 3'd1,
        ST_RDWAIT      = 3'd2,
        ST_RESP        = 3'd3
`ifdef AVMM_INITIATOR_VERIFY_EN
        ,
        ST_VERIFY_RD   = 3'd4,
        ST_VERIFY_WAIT = 3'd5
`endif
    } avmm_state_e;

    // Sized to the package widths; instance ADDR_W/DATA_W must not exceed them.
    typedef struct packed {
        logic                   rnw;
        logic [AVMM_ADDR_W-1:0] addr;
        logic [AVMM_DATA_W-1:0] data;
    } avmm_req_t;

endpackage

// File: rtl/avmm_stall_timer.sv
// Loadable down-counter shared by the stall timeout and the read-latency wait.
// o_expired marks the last counted cycle (count equal to one).
module avmm_stall_timer #(
    parameter int W = 5
) (
    input  logic         i_clk,
    input  logic         i_reset_n,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    input  logic         i_en,
    output logic         o_expired
);

    logic [W-1:0] r_count;

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_en && (r_count != '0)) begin
            r_count <= r_count - 1'b1;
        end
    end

    assign o_expired = (r_count == W'(1));

endmodule

// File: rtl/avmm_bus_initiator.sv
// Avalon-MM initiator: one registered single-word access at a time with waitrequest,
// fixed read latency and stall timeout. Optional write readback: AVMM_INITIATOR_VERIFY_EN.
module avmm_bus_initiator
    import avmm_pkg::*;
#(
    parameter int ADDR_W       = AVMM_ADDR_W,
    parameter int DATA_W       = AVMM_DATA_W,
    parameter int READ_LATENCY = AVMM_READ_LATENCY,
    parameter int TIMEOUT_CYC  = AVMM_TIMEOUT_CYC
) (
    input  logic              i_clk,
    input  logic              i_reset_n,
    input  logic              i_req_valid,
    output logic              o_req_ready,
    input  logic              i_req_rnw,
    input  logic [ADDR_W-1:0] i_req_addr,
    input  logic [DATA_W-1:0] i_req_data,
    output logic              o_rsp_valid,
    output logic [DATA_W-1:0] o_rsp_data,
    output logic              o_rsp_err,
    output logic [ADDR_W-1:0] o_avm_address,
    output logic              o_avm_chipselect,
    output logic              o_avm_write,
    output logic              o_avm_read,
    output logic [DATA_W-1:0] o_avm_writedata,
    input  logic [DATA_W-1:0] i_avm_readdata,
    input  logic              i_avm_waitrequest
);

    localparam int CNT_MAX = (TIMEOUT_CYC > READ_LATENCY) ? TIMEOUT_CYC : READ_LATENCY;
    localparam int CNT_W   = $clog2(CNT_MAX + 2);
    localparam logic [CNT_W-1:0] TO_LOAD = CNT_W'(TIMEOUT_CYC);
    localparam logic [CNT_W-1:0] RL_LOAD = CNT_W'(READ_LATENCY);
    localparam bit TO_EN = (TIMEOUT_CYC != 0);

    avmm_state_e       r_state, w_state;
    avmm_req_t         r_req, w_req;
    logic              r_avm_cs, w_avm_cs;
    logic              r_avm_wr, w_avm_wr;
    logic              r_avm_rd, w_avm_rd;
    logic              r_rsp_valid;
    logic [DATA_W-1:0] r_rsp_data, w_rsp_data;
    logic              r_rsp_err, w_rsp_err;
    logic              w_tmr_load, w_tmr_en, w_tmr_expired;
    logic [CNT_W-1:0]  w_tmr_val;

    avmm_stall_timer #(.W(CNT_W)) u_stall_timer (
        .i_clk      (i_clk),
        .i_reset_n  (i_reset_n),
        .i_load     (w_tmr_load),
        .i_load_val (w_tmr_val),
        .i_en       (w_tmr_en),
        .o_expired  (w_tmr_expired)
    );

    // Next-state and next bus/response register values; every bus output is a flop.
    always_comb begin
        w_state    = r_state;
        w_req      = r_req;
        w_avm_cs   = r_avm_cs;
        w_avm_wr   = r_avm_wr;
        w_avm_rd   = r_avm_rd;
        w_rsp_data = r_rsp_data;
        w_rsp_err  = r_rsp_err;
        w_tmr_load = 1'b0;
        w_tmr_val  = TO_LOAD;
        w_tmr_en   = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (i_req_valid) begin
                    w_req.rnw  = i_req_rnw;
                    w_req.addr = AVMM_ADDR_W'(i_req_addr);
                    w_req.data = i_req_rnw ? '0 : AVMM_DATA_W'(i_req_data);
                    w_avm_cs   = 1'b1;
                    w_avm_wr   = !i_req_rnw;
                    w_avm_rd   = i_req_rnw;
                    w_tmr_load = 1'b1;
                    w_state    = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                if (!i_avm_waitrequest) begin
                    w_avm_cs = 1'b0;
                    w_avm_wr = 1'b0;
                    w_avm_rd = 1'b0;
                    if (!r_req.rnw) begin
`ifdef AVMM_INITIATOR_VERIFY_EN
                        w_avm_cs   = 1'b1;
                        w_avm_rd   = 1'b1;
                        w_tmr_load = 1'b1;
                        w_state    = ST_VERIFY_RD;
`else
                        w_rsp_data = '0;
                        w_rsp_err  = 1'b0;
                        w_state    = ST_RESP;
`endif
                    end else if (READ_LATENCY == 0) begin
                        w_rsp_data = i_avm_readdata;
                        w_rsp_err  = 1'b0;
                        w_state    = ST_RESP;
                    end else begin
                        w_tmr_load = 1'b1;
                        w_tmr_val  = RL_LOAD;
                        w_state    = ST_RDWAIT;
                    end
                end else if (TO_EN && w_tmr_expired) begin
                    w_avm_cs   = 1'b0;
                    w_avm_wr   = 1'b0;
                    w_avm_rd   = 1'b0;
                    w_rsp_data = '0;
                    w_rsp_err  = 1'b1;
                    w_state    = ST_RESP;
                end else begin
                    w_tmr_en = 1'b1;
                end
            end
            ST_RDWAIT: begin
                w_tmr_en = 1'b1;
                if (w_tmr_expired) begin
                    w_rsp_data = i_avm_readdata;
                    w_rsp_err  = 1'b0;
                    w_state    = ST_RESP;
                end
            end
            ST_RESP: begin
                w_state = ST_IDLE;
            end
`ifdef AVMM_INITIATOR_VERIFY_EN
            // Readback compares against the data latched for the write just completed.
            ST_VERIFY_RD: begin
                if (!i_avm_waitrequest) begin
                    w_avm_cs = 1'b0;
                    w_avm_rd = 1'b0;
                    if (READ_LATENCY == 0) begin
                        w_rsp_data = i_avm_readdata;
                        w_rsp_err  = (i_avm_readdata != r_req.data[DATA_W-1:0]);
                        w_state    = ST_RESP;
                    end else begin
                        w_tmr_load = 1'b1;
                        w_tmr_val  = RL_LOAD;
                        w_state    = ST_VERIFY_WAIT;
                    end
                end else if (TO_EN && w_tmr_expired) begin
                    w_avm_cs   = 1'b0;
                    w_avm_rd   = 1'b0;
                    w_rsp_data = '0;
                    w_rsp_err  = 1'b1;
                    w_state    = ST_RESP;
                end else begin
                    w_tmr_en = 1'b1;
                end
            end
            ST_VERIFY_WAIT: begin
                w_tmr_en = 1'b1;
                if (w_tmr_expired) begin
                    w_rsp_data = i_avm_readdata;
                    w_rsp_err  = (i_avm_readdata != r_req.data[DATA_W-1:0]);
                    w_state    = ST_RESP;
                end
            end
`endif
            default: begin
                w_state = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state     <= ST_IDLE;
            r_req       <= '0;
            r_avm_cs    <= 1'b0;
            r_avm_wr    <= 1'b0;
            r_avm_rd    <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_data  <= '0;
            r_rsp_err   <= 1'b0;
        end else begin
            r_state     <= w_state;
            r_req       <= w_req;
            r_avm_cs    <= w_avm_cs;
            r_avm_wr    <= w_avm_wr;
            r_avm_rd    <= w_avm_rd;
            r_rsp_valid <= (w_state == ST_RESP);
            r_rsp_data  <= w_rsp_data;
            r_rsp_err   <= w_rsp_err;
        end
    end

    assign o_req_ready      = (r_state == ST_IDLE);
    assign o_rsp_valid      = r_rsp_valid;
    assign o_rsp_data       = r_rsp_data;
    assign o_rsp_err        = r_rsp_err;
    assign o_avm_address    = r_req.addr[ADDR_W-1:0];
    assign o_avm_chipselect = r_avm_cs;
    assign o_avm_write      = r_avm_wr;
    assign o_avm_read       = r_avm_rd;
    assign o_avm_writedata  = r_req.data[DATA_W-1:0];

endmodule

// File: tb/tb_avmm_bus_initiator.sv
// Scoreboard bench for avmm_bus_initiator: randomized requests against a memory-model slave.
// Expected responses and their cycle come from transaction-level rules, not the RTL.
`timescale 1ns/1ps
module tb_avmm_bus_initiator;

    localparam int ADDR_W = 2;
    localparam int DATA_W = 32;
    localparam int RL     = 1;
    localparam int TO     = 16;

    typedef struct {
        logic [DATA_W-1:0] data;
        logic              err;
        int                cycle;
    } expRsp_t;

    logic              clk = 1'b0;
    logic              resetN;
    logic              reqValid, reqReady, reqRnw;
    logic [ADDR_W-1:0] reqAddr;
    logic [DATA_W-1:0] reqData;
    logic              rspValid, rspErr;
    logic [DATA_W-1:0] rspData;
    logic              avmCs, avmWr, avmRd, avmWait;
    logic [ADDR_W-1:0] avmAddr;
    logic [DATA_W-1:0] avmWdata, avmRdata;

    expRsp_t           expQ[$];
    expRsp_t           monExp;
    int                stallQ[$];
    logic [DATA_W-1:0] refMem[4];
    logic [DATA_W-1:0] slaveMem[4];
    int                vectors = 0;
    int                miscompares = 0;
    int                cycleCnt = 0;
    bit                corruptNext = 1'b0;

    bit                inAccess = 1'b0;
    bit                followOn = 1'b0;
    int                stallCnt = 0;
    int                curTarget = 0;
    int                pendCnt = 0;
    logic [DATA_W-1:0] pendVal;
    logic [DATA_W-1:0] slvVal;
    logic [ADDR_W+DATA_W+1:0] prevBus;

    avmm_bus_initiator #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .READ_LATENCY(RL), .TIMEOUT_CYC(TO)
    ) dut (
        .i_clk             (clk),
        .i_reset_n         (resetN),
        .i_req_valid       (reqValid),
        .o_req_ready       (reqReady),
        .i_req_rnw         (reqRnw),
        .i_req_addr        (reqAddr),
        .i_req_data        (reqData),
        .o_rsp_valid       (rspValid),
        .o_rsp_data        (rspData),
        .o_rsp_err         (rspErr),
        .o_avm_address     (avmAddr),
        .o_avm_chipselect  (avmCs),
        .o_avm_write       (avmWr),
        .o_avm_read        (avmRd),
        .o_avm_writedata   (avmWdata),
        .i_avm_readdata    (avmRdata),
        .i_avm_waitrequest (avmWait)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycleCnt <= cycleCnt + 1;

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, actual, expected, cycleCnt);
        end
    endtask

    // Slave model: stalls each new access by its queued count, stores writes, returns reads RL cycles later.
    always @(negedge clk) begin
        if (!resetN) begin
            inAccess = 1'b0;
            followOn = 1'b0;
            stallCnt = 0;
            pendCnt  = 0;
            avmWait  = 1'b0;
        end else begin
            avmRdata = $urandom;
            if (pendCnt > 0) begin
                pendCnt--;
                if (pendCnt == 0) avmRdata = pendVal;
            end
            if (avmCs) begin
                if (!inAccess) begin
                    inAccess  = 1'b1;
                    stallCnt  = 0;
                    curTarget = 0;
                    if (!followOn && stallQ.size() != 0) curTarget = stallQ.pop_front();
                end else begin
                    checkOutput("bus_stable", 64'({avmAddr, avmWr, avmRd, avmWdata}), 64'(prevBus));
                end
                prevBus = {avmAddr, avmWr, avmRd, avmWdata};
                checkOutput("stall_bound", 64'(stallCnt < TO), 64'(1));
                if (stallCnt < curTarget) begin
                    avmWait = 1'b1;
                    stallCnt++;
                end else begin
                    avmWait  = 1'b0;
                    inAccess = 1'b0;
                    followOn = 1'b1;
                    if (avmWr) begin
                        slaveMem[avmAddr] = avmWdata;
                    end else begin
                        slvVal = slaveMem[avmAddr];
                        if (corruptNext) begin
                            slvVal      = 32'h0000_000B;
                            corruptNext = 1'b0;
                        end
                        if (RL == 0) avmRdata = slvVal;
                        else begin
                            pendCnt = RL;
                            pendVal = slvVal;
                        end
                    end
                end
            end else begin
                avmWait  = 1'b0;
                inAccess = 1'b0;
                followOn = 1'b0;
            end
        end
    end

    // Monitor: bus strobe shape every cycle, and every response popped against the scoreboard.
    always @(negedge clk) begin
        if (resetN) begin
            checkOutput("strobe_shape", 64'({avmCs, avmRd | avmWr, avmRd & avmWr}),
                        64'(avmCs ? 3'b110 : 3'b000));
            if (rspValid) begin
                checkOutput("rsp_expected", 64'(expQ.size() != 0), 64'(1));
                if (expQ.size() != 0) begin
                    monExp = expQ.pop_front();
                    checkOutput("rsp_data", 64'(rspData), 64'(monExp.data));
                    checkOutput("rsp_err", 64'(rspErr), 64'(monExp.err));
                    checkOutput("rsp_cycle", 64'(cycleCnt), 64'(monExp.cycle));
                end
            end
        end
    end

    // Called on a falling edge; holds the request until accepted and records what must come back.
    task automatic applyStimulus(input logic rnw, input logic [ADDR_W-1:0] addr,
                                 input logic [DATA_W-1:0] data, input int stall, input bit corrupt);
        int      waitCyc = 0;
        expRsp_t e;
        reqValid = 1'b1;
        reqRnw   = rnw;
        reqAddr  = addr;
        reqData  = data;
        while (!reqReady && waitCyc < 200) begin
            @(negedge clk);
            waitCyc++;
        end
        checkOutput("ready_wait", 64'(waitCyc < 200), 64'(1));
        if (waitCyc >= 200) begin
            reqValid = 1'b0;
            return;
        end
        stallQ.push_back(stall);
        corruptNext = corrupt;
        if (stall >= TO) begin
            e.data  = '0;
            e.err   = 1'b1;
            e.cycle = cycleCnt + 1 + TO;
        end else if (rnw) begin
            e.data  = refMem[addr];
            e.err   = 1'b0;
            e.cycle = cycleCnt + 2 + stall + RL;
        end else begin
            refMem[addr] = data;
`ifdef AVMM_INITIATOR_VERIFY_EN
            e.data  = corrupt ? 32'h0000_000B : data;
            e.err   = corrupt && (data != 32'h0000_000B);
            e.cycle = cycleCnt + 3 + stall + RL;
`else
            e.data  = '0;
            e.err   = 1'b0;
            e.cycle = cycleCnt + 2 + stall;
`endif
        end
        expQ.push_back(e);
        @(negedge clk);
        reqValid = 1'b0;
    endtask

    task automatic drainQueue();
        int n = 0;
        while (expQ.size() != 0 && n < 400) begin
            @(negedge clk);
            n++;
        end
        checkOutput("drain_empty", 64'(expQ.size()), 64'(0));
    endtask

    initial begin
        int r;
        int stall;
        resetN   = 1'b0;
        reqValid = 1'b0;
        reqRnw   = 1'b0;
        reqAddr  = '0;
        reqData  = '0;
        avmWait  = 1'b0;
        avmRdata = '0;
        for (int i = 0; i < 4; i++) begin
            refMem[i]   = $urandom;
            slaveMem[i] = refMem[i];
        end
        repeat (3) @(negedge clk);
        checkOutput("reset_ready", 64'(reqReady), 64'(1));
        checkOutput("reset_bus", 64'({avmCs, avmWr, avmRd, avmAddr, avmWdata}), 64'(0));
        checkOutput("reset_rsp", 64'({rspValid, rspErr, rspData}), 64'(0));
        resetN = 1'b1;
        @(negedge clk);

        applyStimulus(1'b0, 2'd0, 32'h0000_0005, 0, 1'b0);
        applyStimulus(1'b0, 2'd1, 32'h0000_007F, 0, 1'b0);
        applyStimulus(1'b1, 2'd1, 32'h0, 0, 1'b0);
        applyStimulus(1'b0, 2'd2, 32'h0000_1234, 5, 1'b0);
        applyStimulus(1'b0, 2'd3, 32'h0000_DEAD, 20, 1'b0);
        applyStimulus(1'b1, 2'd3, 32'h0, TO, 1'b0);
        applyStimulus(1'b1, 2'd2, 32'h0, TO - 1, 1'b0);

        for (int i = 0; i < 60; i++) begin
            r = int'($urandom_range(0, 9));
            if (r < 6)      stall = 0;
            else if (r < 9) stall = int'($urandom_range(1, 6));
            else            stall = int'($urandom_range(TO, TO + 4));
            applyStimulus(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), $urandom, stall, 1'b0);
        end

`ifdef AVMM_INITIATOR_VERIFY_EN
        applyStimulus(1'b0, 2'd1, 32'h0000_000A, 0, 1'b1);
`endif
        drainQueue();
        repeat (2) @(negedge clk);

        // Reset in the middle of a stalled write: strobes must drop without waiting for a clock.
        stallQ.push_back(8);
        reqValid = 1'b1;
        reqRnw   = 1'b0;
        reqAddr  = 2'd2;
        reqData  = 32'h0000_0055;
        @(negedge clk);
        reqValid = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("pre_reset_write", 64'({avmCs, avmWr}), 64'(2'b11));
        #1 resetN = 1'b0;
        #1;
        checkOutput("async_reset_bus", 64'({avmCs, avmWr, avmRd}), 64'(0));
        @(negedge clk);
        resetN = 1'b1;
        stallQ.delete();
        checkOutput("ready_after_reset", 64'(reqReady), 64'(1));
        repeat (10) @(negedge clk);
        applyStimulus(1'b1, 2'd2, 32'h0, 0, 1'b0);
        drainQueue();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/avmm_bus_initiator.md
Name: avmm_bus_initiator

Overview:
- Avalon-MM initiator (master) that drives single-word register accesses into our memory-mapped peripherals: the seven-segment decoder, LED and switch blocks.
- Sits between a local request/response handshake (sequencer, test FSM or soft-core glue) and the peripheral's slave port: address, chipselect, write, writedata, readdata.
- Serialises one access at a time and handles waitrequest stalls, fixed read latency and a stall timeout.

Parameters:
- ADDR_W, 2, width of avm_address and req_addr (word address).
- DATA_W, 32, data width of all data ports.
- READ_LATENCY, 1, cycles from read accepted (waitrequest low) to readdata valid; range 0..3.
- TIMEOUT_CYC, 16, consecutive waitrequest-high cycles before abort; 0 disables the timeout.

Ports:
- clk  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- req_valid  in  1  local request present.
- req_ready  out  1  initiator can accept a request.
- req_rnw  in  1  1 = read, 0 = write.
- req_addr  in  ADDR_W  target word address.
- req_data  in  DATA_W  write data.
- rsp_valid  out  1  one-cycle completion pulse.
- rsp_data  out  DATA_W  read data; 0 for writes.
- rsp_err  out  1  access aborted by timeout (or verify mismatch when the optional feature is enabled).
- avm_address  out  ADDR_W  bus address.
- avm_chipselect  out  1  bus select.
- avm_write  out  1  write strobe.
- avm_read  out  1  read strobe.
- avm_writedata  out  DATA_W  bus write data.
- avm_readdata  in  DATA_W  bus read data.
- avm_waitrequest  in  1  slave stall; tie 0 for slaves without it.

Behaviour:
- Reset (async, reset_n low):
  - State = IDLE; req_ready=1.
  - All avm_* outputs 0; rsp_valid=0, rsp_data=0, rsp_err=0; counters 0.
  - Asserting reset mid-access drops all strobes immediately; no response is issued for that access.
- FSM states: IDLE, ACCESS, RDWAIT, RESP (plus VERIFY_RD and VERIFY_WAIT under the option).
- IDLE:
  - req_ready=1.
  - On req_valid, latch addr/data/rnw and go to ACCESS. Inputs are not sampled otherwise.
- ACCESS:
  - Drives avm_chipselect=1, avm_address, and avm_write=!rnw or avm_read=rnw; avm_writedata=latched data (0 on reads).
  - Outputs are registered and stable for the whole state.
  - The access completes on the first cycle with avm_waitrequest=0:
    - Write: go to RESP with rsp_data=0, rsp_err=0.
    - Read with READ_LATENCY=0: capture avm_readdata in that cycle and go to RESP.
    - Read with READ_LATENCY>0: go to RDWAIT; strobes deassert.
  - Timeout: a counter increments each cycle waitrequest=1. If it equals TIMEOUT_CYC (TIMEOUT_CYC≠0), deassert strobes and go to RESP with rsp_err=1, rsp_data=0.
  - The counter clears on entry to ACCESS.
- RDWAIT:
  - Counts READ_LATENCY cycles after acceptance.
  - Captures avm_readdata on the cycle the count completes, then goes to RESP.
- RESP:
  - rsp_valid=1 for exactly one cycle; rsp_data and rsp_err are held until the next response.
  - req_ready=0. Returns to IDLE.
- Latency with waitrequest=0:
  - Write: request accepted cycle N, strobes visible cycle N+1, rsp_valid cycle N+2.
  - Read: rsp_valid at cycle N+2+READ_LATENCY.
- Throughput: one access per 3 cycles minimum; req_ready is low from acceptance until return to IDLE.
- A req_valid during non-IDLE states is ignored; the requester holds it.

Optional Feature:
- Macro: AVMM_INITIATOR_VERIFY_EN.
- With the macro defined:
  - After every completed (non-timed-out) write, the initiator issues a read to the same address (VERIFY_RD, same waitrequest and timeout rules, then VERIFY_WAIT for READ_LATENCY).
  - It compares readdata to the written data: rsp_err=1 on mismatch, and rsp_data=readback value.
  - Write latency grows by 1+READ_LATENCY cycles minimum.
- Without the macro: writes complete as above; those states do not exist.

Decomposition:
- Package avmm_pkg holds:
  - FSM state enum.
  - Parameter default constants (DATA_W, READ_LATENCY, TIMEOUT_CYC).
  - A request struct {rnw, addr, data}.
- One natural sub-module: avmm_stall_timer. It is the shared timeout/latency down-counter, with load, enable and expired outputs, used for both the timeout and RDWAIT counting.

Test Plan:
- Write 0x00000005 to addr 0 with waitrequest=0 -> single-cycle bus write with chipselect=1, write=1, data 5; rsp_valid 2 cycles after accept, rsp_err=0.
- Read addr 1, READ_LATENCY=1, slave returns 0x0000007F -> read strobe 1 cycle, rsp_data=0x7F at accept+3.
- Write with waitrequest held high 5 cycles -> strobes held stable for 6 cycles, rsp_err=0.
- Waitrequest stuck high, TIMEOUT_CYC=16 -> strobes drop after 16 stalled cycles, rsp_valid with rsp_err=1, rsp_data=0.
- Drop reset_n mid-ACCESS -> avm_write/avm_chipselect go to 0 asynchronously, no rsp_valid, req_ready=1 after release.
- Verify option on: write 0x0A, slave returns 0x0B -> read issued to same address, rsp_err=1, rsp_data=0x0B.
